// File: rtl/usb_audio_echo_loop.sv
// Loopback / delay / echo processor for USB audio samples: one shared circular
// buffer, all channels processed in parallel through a CLEAR/IDLE/RD/CALC/WR FSM.
module usb_audio_echo_loop #(
    parameter int CH         = 2,
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic [DEPTH_LOG2-1:0] delay,
    input  logic [2:0]            echo_shift,
    input  logic                  audio_en,
    input  logic [CH*WIDTH-1:0]   audio_o,
    output logic [CH*WIDTH-1:0]   audio_i,
    output logic                  busy,
    output logic                  ovr,
    output logic                  sat
);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        CALC,
        WR
    } state_t;

    typedef enum logic [1:0] {
        M_MUTE,
        M_LOOP,
        M_DELAY,
        M_ECHO
    } mode_t;

    state_t                  state;
    state_t                  state_next;
    logic [DEPTH_LOG2-1:0]   clr_cnt;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_addr;
    logic                    capture;
    logic                    drop;

    // Sample in flight, frozen at the capture cycle
    logic [CH*WIDTH-1:0]     x_reg;
    mode_t                   mode_reg;
    logic [DEPTH_LOG2-1:0]   delay_reg;
    logic [2:0]              shift_reg;
    logic                    delay_zero;

    logic [CH*WIDTH-1:0]     rd_data;
    logic [CH*WIDTH-1:0]     y_calc;
    logic [CH*WIDTH-1:0]     y_reg;
    logic [CH-1:0]           clamp_vec;

    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [CH*WIDTH-1:0]     mem_wdata;
    logic [CH*WIDTH-1:0]     mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drop       = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            CLEAR: begin
                if (&clr_cnt) state_next = IDLE;
            end
            IDLE: begin
                if (audio_en) begin
                    capture    = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                drop       = audio_en;
                state_next = CALC;
            end
            CALC: begin
                drop       = audio_en;
                state_next = WR;
            end
            WR: begin
                drop       = audio_en;
                state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        rd_addr    = wr_ptr - delay_reg;
        delay_zero = (delay_reg == '0);
        mem_we     = 1'b0;
        mem_addr   = clr_cnt;
        mem_wdata  = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (state == WR) begin
            mem_we    = 1'b1;
            mem_addr  = wr_ptr;
            // Echo feeds the processed sample back; every other mode stores the dry input
            mem_wdata = (mode_reg == M_ECHO) ? y_reg : x_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            wr_ptr  <= '0;
            audio_i <= '0;
            ovr     <= 1'b0;
            sat     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
            if (drop) ovr <= 1'b1;
            if (state == CALC && |clamp_vec) sat <= 1'b1;
            if (state == WR) begin
                audio_i <= y_reg;
                wr_ptr  <= wr_ptr + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            x_reg     <= audio_o;
            mode_reg  <= mode_t'(mode);
            delay_reg <= delay;
            shift_reg <= echo_shift;
        end
        if (state == RD) rd_data <= mem[rd_addr];
        if (state == CALC) y_reg <= y_calc;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] bs;
        logic signed [WIDTH-1:0] es;
        logic signed [WIDTH-1:0] ys;
        logic signed [WIDTH:0]   sum;
        logic                    clamp;

        always_comb begin
            xs    = x_reg[k*WIDTH +: WIDTH];
            bs    = rd_data[k*WIDTH +: WIDTH];
            es    = bs >>> shift_reg;
            sum   = {xs[WIDTH-1], xs} + {es[WIDTH-1], es};
            clamp = 1'b0;
            ys    = xs;
            unique case (mode_reg)
                M_MUTE:  ys = '0;
                M_LOOP:  ys = xs;
                M_DELAY: ys = delay_zero ? xs : bs;
                M_ECHO: begin
                    if (!delay_zero) begin
                        // Disagreeing top two bits of the widened sum means overflow
                        if (sum[WIDTH] != sum[WIDTH-1]) begin
                            clamp = 1'b1;
                            ys    = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                        end else begin
                            ys = sum[WIDTH-1:0];
                        end
                    end
                end
            endcase
        end

        assign y_calc[k*WIDTH +: WIDTH] = ys;
        assign clamp_vec[k]             = clamp;
    end

endmodule

// File: tb/tb_usb_audio_echo_loop.sv
// Directed bench for usb_audio_echo_loop: a behavioural buffer model predicts each
// output, pushes it to a scoreboard queue, and it is popped when the DUT finishes.
module tb_usb_audio_echo_loop;

    localparam int CH    = 2;
    localparam int WIDTH = 16;
    localparam int DL    = 4;

    logic                clk;
    logic                rstn;
    logic [1:0]          mode;
    logic [DL-1:0]       delay;
    logic [2:0]          echo_shift;
    logic                audio_en;
    logic [CH*WIDTH-1:0] audio_o;
    logic [CH*WIDTH-1:0] audio_i;
    logic                busy;
    logic                ovr;
    logic                sat;

    usb_audio_echo_loop #(
        .CH(CH),
        .WIDTH(WIDTH),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .mode(mode),
        .delay(delay),
        .echo_shift(echo_shift),
        .audio_en(audio_en),
        .audio_o(audio_o),
        .audio_i(audio_i),
        .busy(busy),
        .ovr(ovr),
        .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mbuf [16];
    logic [3:0]  mwp;
    logic        msat;
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        mwp  = '0;
        msat = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic [1:0] m, input logic [3:0] d, input logic [2:0] s,
                              input logic [31:0] x, output logic [31:0] y);
        logic [3:0]  ra;
        logic [31:0] b;
        ra = mwp - d;
        b  = mbuf[ra];
        y  = '0;
        for (int c = 0; c < CH; c++) begin
            int xs;
            int bs;
            int e;
            int sum;
            int yc;
            xs  = $signed(x[c*16 +: 16]);
            bs  = $signed(b[c*16 +: 16]);
            e   = bs >>> s;
            sum = xs + e;
            yc  = xs;
            case (m)
                2'd0: yc = 0;
                2'd1: yc = xs;
                2'd2: yc = (d == 0) ? xs : bs;
                default: begin
                    if (d == 0) yc = xs;
                    else if (sum > 32767) begin yc = 32767; msat = 1'b1; end
                    else if (sum < -32768) begin yc = -32768; msat = 1'b1; end
                    else yc = sum;
                end
            endcase
            y[c*16 +: 16] = yc[15:0];
        end
        mbuf[mwp] = (m == 2'd3) ? y : x;
        mwp = mwp + 4'd1;
    endtask

    task automatic assert_reset(input string tag);
        rstn     = 1'b0;
        audio_en = 1'b0;
        #1;
        check({tag, "_rst_audio_i"}, audio_i, 32'd0);
        check({tag, "_rst_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_rst_ovr"}, {31'd0, ovr}, 32'd0);
        check({tag, "_rst_sat"}, {31'd0, sat}, 32'd0);
        model_clear();
    endtask

    task automatic release_and_count(input bit poke, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rstn = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            audio_en = (poke && n == 5);
            if (!busy) break;
        end
        audio_en = 1'b0;
        check({tag, "_clear_cycles"}, n, 32'd16);
        check({tag, "_idle_audio_i"}, audio_i, 32'd0);
        check({tag, "_idle_ovr"}, {31'd0, ovr}, 32'd0);
        check({tag, "_idle_sat"}, {31'd0, sat}, 32'd0);
    endtask

    task automatic full_reset(input bit poke, input string tag);
        @(negedge clk);
        assert_reset(tag);
        #3;
        release_and_count(poke, tag);
    endtask

    task automatic scramble();
        mode       = 2'($urandom);
        delay      = 4'($urandom);
        echo_shift = 3'($urandom);
        audio_o    = $urandom;
    endtask

    task automatic do_sample(input logic [1:0] m, input logic [3:0] d, input logic [2:0] s,
                             input logic [31:0] x, input string tag);
        logic [31:0] y;
        int n;
        @(negedge clk);
        mode       = m;
        delay      = d;
        echo_shift = s;
        audio_o    = x;
        audio_en   = 1'b1;
        model_step(m, d, s, x, y);
        sb_q.push_back(y);
        @(posedge clk);
        #1;
        audio_en = 1'b0;
        scramble();
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 32'd3);
        check({tag, "_audio_i"}, audio_i, sb_q.pop_front());
        check({tag, "_sat"}, {31'd0, sat}, {31'd0, msat});
    endtask

    // Accepted DELAY(1) strobe followed by an illegal one 'gap' cycles later
    task automatic overrun_case(input int gap, input logic [31:0] x, input string tag);
        logic [31:0] y;
        int n;
        @(negedge clk);
        mode       = 2'd2;
        delay      = 4'd1;
        echo_shift = 3'd0;
        audio_o    = x;
        audio_en   = 1'b1;
        model_step(2'd2, 4'd1, 3'd0, x, y);
        sb_q.push_back(y);
        @(posedge clk);
        #1;
        audio_en = 1'b0;
        repeat (gap) @(negedge clk);
        audio_o  = x ^ 32'h5A5A_5A5A;
        mode     = 2'd1;
        audio_en = 1'b1;
        @(posedge clk);
        #1;
        audio_en = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_ovr"}, {31'd0, ovr}, 32'd1);
        check({tag, "_audio_i"}, audio_i, sb_q.pop_front());
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rstn       = 1'b0;
        mode       = '0;
        delay      = '0;
        echo_shift = '0;
        audio_en   = 1'b0;
        audio_o    = '0;
        model_clear();
        #12;

        full_reset(1'b0, "reset");
        full_reset(1'b1, "clear_strobe");

        do_sample(2'd1, 4'd0, 3'd0, 32'hFFFE_1234, "loop");
        check("loop_const", audio_i, 32'hFFFE_1234);
        do_sample(2'd1, 4'd5, 3'd3, 32'h8001_7FFF, "loop2");
        do_sample(2'd0, 4'd2, 3'd0, 32'h1234_5678, "mute");

        full_reset(1'b0, "r_delay3");
        for (int i = 1; i <= 5; i++)
            do_sample(2'd2, 4'd3, 3'd0, {16'(i + 100), 16'(i)}, "delay3");
        check("delay3_last_ch0", {16'd0, audio_i[15:0]}, 32'd2);

        full_reset(1'b0, "r_wrap");
        for (int i = 1; i <= 20; i++)
            do_sample(2'd2, 4'd15, 3'd0, {16'(-i), 16'(i)}, "wrap");
        check("wrap_last_ch0", {16'd0, audio_i[15:0]}, 32'd5);

        full_reset(1'b0, "r_echo");
        do_sample(2'd3, 4'd1, 3'd1, {16'hFC18, 16'd1000}, "echo");
        do_sample(2'd3, 4'd1, 3'd1, 32'd0, "echo");
        do_sample(2'd3, 4'd1, 3'd1, 32'd0, "echo");
        check("echo_last_ch0", {16'd0, audio_i[15:0]}, 32'd250);
        do_sample(2'd3, 4'd0, 3'd2, 32'h7FFF_4000, "echo_d0");

        full_reset(1'b0, "r_satp");
        do_sample(2'd3, 4'd1, 3'd0, 32'h0000_7000, "sat_pos");
        do_sample(2'd3, 4'd1, 3'd0, 32'h0000_7000, "sat_pos");
        check("sat_pos_flag", {31'd0, sat}, 32'd1);
        full_reset(1'b0, "r_satn");
        do_sample(2'd3, 4'd1, 3'd0, 32'h9000_0000, "sat_neg");
        do_sample(2'd3, 4'd1, 3'd0, 32'h9000_0000, "sat_neg");
        do_sample(2'd1, 4'd0, 3'd0, 32'h0001_0001, "sat_sticky");

        full_reset(1'b0, "r_ovr");
        do_sample(2'd2, 4'd1, 3'd0, 32'h0005_000A, "ovr_seq");
        overrun_case(2, 32'h0006_0014, "ovr_calc");
        do_sample(2'd2, 4'd1, 3'd0, 32'h0007_001E, "ovr_seq");
        overrun_case(3, 32'h0008_0028, "ovr_wr");
        do_sample(2'd2, 4'd1, 3'd0, 32'h0009_0032, "ovr_seq");
        check("ovr_sticky", {31'd0, ovr}, 32'd1);

        full_reset(1'b0, "r_mid");
        for (int i = 1; i <= 16; i++)
            do_sample(2'd1, 4'd0, 3'd0, {16'(i * 3), 16'(i + 7)}, "fill");
        @(negedge clk);
        audio_o  = 32'h1111_2222;
        mode     = 2'd1;
        audio_en = 1'b1;
        @(posedge clk);
        #1;
        audio_en = 1'b0;
        @(posedge clk);
        #2;
        check("mid_busy_calc", {31'd0, busy}, 32'd1);
        assert_reset("mid");
        #3;
        release_and_count(1'b0, "mid");
        do_sample(2'd2, 4'd1, 3'd0, 32'h0A0A_0B0B, "after_mid");
        do_sample(2'd2, 4'd6, 3'd0, 32'h0C0C_0D0D, "after_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
